checksum_strip_verify: RTL and testbench
========================================

// Module: checksum_strip_verify
// PURPOSE
// Receive-side counterpart of the host checksum-append path: consumes an AXI4SR packet made of N data beats
// followed by one trailing checksum beat, recomputes the checksum over the data beats, strips the trailer,
// and forwards the data beats with tlast moved onto the last data beat. One status pulse per packet reports
// the match result. Sits between the network/host ingress FIFO and the user consumer.
// PARAMETERS
// DATA_BITS  512  stream data width; multiple of 32
// PID_BITS   6    tid width
// PORTS
// aclk                 in   1              clock
// areset               in   1              reset: synchronous, active-low
// s_axis_host_tvalid   in   1              input beat valid
// s_axis_host_tready   out  1              input beat ready
// s_axis_host_tdata    in   DATA_BITS      input data / checksum in [31:0] on trailer
// s_axis_host_tkeep    in   DATA_BITS/8    byte enables
// s_axis_host_tid      in   PID_BITS       stream id
// s_axis_host_tlast    in   1              marks the checksum trailer beat
// m_axis_host_tvalid   out  1              output beat valid
// m_axis_host_tready   in   1              output beat ready
// m_axis_host_tdata    out  DATA_BITS      data beat
// m_axis_host_tkeep    out  DATA_BITS/8    byte enables
// m_axis_host_tid      out  PID_BITS       stream id
// m_axis_host_tlast    out  1              last data beat of packet
// chk_done             out  1              1-cycle pulse: packet verdict valid
// chk_ok               out  1              1 = received checksum equals computed
// chk_tid              out  PID_BITS       tid of first data beat of the reported packet
// chk_rcv              out  32             received checksum (trailer tdata[31:0])
// chk_calc             out  32             computed checksum
// BEHAVIOUR
// - Checksum: sum mod 2^32 of all 32-bit lanes of every data beat; bytes with tkeep=0 count as 0x00; carries dropped.
// - Registered output stage O plus one-beat hold register H (beat whose last-ness is not yet known).
// - Input accept condition: s_tready = !O.valid || m_axis_host_tready. O holds until its handshake completes.
// - FSM EMPTY (H empty) / HELD (H full). On accepted beat B:
//   EMPTY, B.tlast=0: H<=B, acc<=lanesum(B), tid_r<=B.tid, ->HELD.
//   EMPTY, B.tlast=1: zero-data packet; nothing forwarded; verdict vs calc=0; stay EMPTY.
//   HELD,  B.tlast=0: O<=H with tlast=0; H<=B; acc+=lanesum(B); stay HELD.
//   HELD,  B.tlast=1: O<=H with tlast=1; verdict acc vs B.tdata[31:0]; acc<=0; ->EMPTY.
// - Verdict: chk_done=1 exactly one cycle after trailer accept; chk_ok/chk_tid/chk_rcv/chk_calc held until next verdict.
// - Latency: data beat k appears on m_axis one cycle after beat k+1 (data or trailer) is accepted.
// - Trailer tkeep/tid ignored; tid of beats 2..N ignored for status.
// - Full throughput: one beat/cycle when m_axis_host_tready=1 continuously.
// - Reset (areset=0 at rising aclk): all outputs 0, FSM EMPTY, acc=0, H/O invalid. Mid-packet reset discards the
//   partial packet; no chk_done is produced for it.
// CONFIGURATION
// CHKV_ERR_CNT_EN defined: adds outputs pkt_good_cnt[31:0], pkt_bad_cnt[31:0]; incremented with chk_done by
//   chk_ok / !chk_ok; saturate at 0xFFFFFFFF; cleared by reset.
// Not defined: ports absent, no counter logic.
// TESTING
// 1. 3 data beats, all lanes 0x00000001, full keep, trailer 0x00000030 -> 3 beats out, tlast on beat 3, chk_done, chk_ok=1, chk_calc=0x30.
// 2. Same packet, trailer 0x00000031 -> identical data out, chk_ok=0, chk_rcv=0x31, chk_calc=0x30 (bad_cnt=1 if CHKV_ERR_CNT_EN).
// 3. 1 data beat, lane0=0xFFFFFFFF, lane1=0x00000002, rest 0, trailer 0x00000001 -> wrap-around, chk_ok=1.
// 4. 1 data beat all lanes 0x01010101, tkeep=0x000F, trailer 0x01010101 -> chk_ok=1; output tkeep=0x000F, tlast=1.
// 5. Trailer-only packet tdata=0 -> no m_axis beat, chk_done, chk_ok=1; tdata=5 -> chk_ok=0.
// 6. Back-to-back 4-beat packets, m_tready toggling 1/0 each cycle, reset pulled mid 2nd packet -> 1st packet intact + one verdict; no output or chk_done from 2nd; 3rd packet after reset verifies ok.

Source files
------------

// File: rtl/checksum_strip_verify.sv
// Strips the trailing checksum beat from each packet and checks it against the 32-bit lane sum of the data beats. Beat k leaves one cycle after beat k+1 is accepted.
// Input is accepted while the output stage is empty or draining. Defining CHKV_ERR_CNT_EN adds saturating good/bad packet counters.
module checksum_strip_verify #(
  parameter int DATA_BITS = 512,
  parameter int PID_BITS  = 6
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_axis_host_tvalid,
  output logic                   s_axis_host_tready,
  input  logic [DATA_BITS-1:0]   s_axis_host_tdata,
  input  logic [DATA_BITS/8-1:0] s_axis_host_tkeep,
  input  logic [PID_BITS-1:0]    s_axis_host_tid,
  input  logic                   s_axis_host_tlast,
  output logic                   m_axis_host_tvalid,
  input  logic                   m_axis_host_tready,
  output logic [DATA_BITS-1:0]   m_axis_host_tdata,
  output logic [DATA_BITS/8-1:0] m_axis_host_tkeep,
  output logic [PID_BITS-1:0]    m_axis_host_tid,
  output logic                   m_axis_host_tlast,
  output logic                   chk_done,
  output logic                   chk_ok,
  output logic [PID_BITS-1:0]    chk_tid,
  output logic [31:0]            chk_rcv,
`ifdef CHKV_ERR_CNT_EN
  output logic [31:0]            pkt_good_cnt,
  output logic [31:0]            pkt_bad_cnt,
`endif
  output logic [31:0]            chk_calc
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int LANES     = DATA_BITS / 32;

  typedef enum logic {EMPTY, HELD} state_t;
  state_t state_q, state_d;

  logic                 o_vld;
  logic [DATA_BITS-1:0] o_dat;
  logic [KEEP_BITS-1:0] o_keep;
  logic [PID_BITS-1:0]  o_tid;
  logic                 o_last;

  logic [DATA_BITS-1:0] h_dat;
  logic [KEEP_BITS-1:0] h_keep;
  logic [PID_BITS-1:0]  h_tid;

  logic [PID_BITS-1:0]  first_tid;
  logic [31:0]          acc;
  logic [DATA_BITS-1:0] masked;
  logic [31:0]          beat_sum;
  logic [31:0]          calc_now;
  logic                 accept;
  logic                 load_h;
  logic                 fwd_h;
  logic                 verdict;
  logic                 rcv_match;

  assign s_axis_host_tready = !o_vld || m_axis_host_tready;
  assign accept             = s_axis_host_tvalid && s_axis_host_tready;
  assign rcv_match          = (s_axis_host_tdata[31:0] == calc_now);

  assign m_axis_host_tvalid = o_vld;
  assign m_axis_host_tdata  = o_dat;
  assign m_axis_host_tkeep  = o_keep;
  assign m_axis_host_tid    = o_tid;
  assign m_axis_host_tlast  = o_last;

  // Disabled bytes contribute zero; lane carries are dropped by the 32-bit sum.
  always_comb begin
    masked = '0;
    for (int i = 0; i < KEEP_BITS; i++) begin
      if (s_axis_host_tkeep[i]) masked[8*i +: 8] = s_axis_host_tdata[8*i +: 8];
    end
    beat_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      beat_sum = beat_sum + masked[32*l +: 32];
    end
  end

  always_comb begin
    state_d  = state_q;
    load_h   = 1'b0;
    fwd_h    = 1'b0;
    verdict  = 1'b0;
    calc_now = '0;
    if (accept) begin
      case (state_q)
        EMPTY: begin
          if (s_axis_host_tlast) begin
            verdict = 1'b1;
          end else begin
            load_h  = 1'b1;
            state_d = HELD;
          end
        end
        HELD: begin
          fwd_h    = 1'b1;
          calc_now = acc;
          if (s_axis_host_tlast) begin
            verdict = 1'b1;
            state_d = EMPTY;
          end else begin
            load_h = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (!areset) begin
      state_q   <= EMPTY;
      o_vld     <= 1'b0;
      o_dat     <= '0;
      o_keep    <= '0;
      o_tid     <= '0;
      o_last    <= 1'b0;
      h_dat     <= '0;
      h_keep    <= '0;
      h_tid     <= '0;
      first_tid <= '0;
      acc       <= '0;
      chk_done  <= 1'b0;
      chk_ok    <= 1'b0;
      chk_tid   <= '0;
      chk_rcv   <= '0;
      chk_calc  <= '0;
    end else begin
      state_q  <= state_d;
      chk_done <= verdict;
      if (fwd_h) begin
        o_vld  <= 1'b1;
        o_dat  <= h_dat;
        o_keep <= h_keep;
        o_tid  <= h_tid;
        o_last <= s_axis_host_tlast;
      end else if (m_axis_host_tready) begin
        o_vld <= 1'b0;
      end
      if (load_h) begin
        h_dat  <= s_axis_host_tdata;
        h_keep <= s_axis_host_tkeep;
        h_tid  <= s_axis_host_tid;
      end
      if (load_h && state_q == EMPTY) begin
        acc       <= beat_sum;
        first_tid <= s_axis_host_tid;
      end else if (load_h) begin
        acc <= acc + beat_sum;
      end else if (verdict) begin
        acc <= '0;
      end
      // A trailer-only packet has no first data beat, so its reported tid is zero.
      if (verdict) begin
        chk_ok   <= rcv_match;
        chk_tid  <= (state_q == HELD) ? first_tid : '0;
        chk_rcv  <= s_axis_host_tdata[31:0];
        chk_calc <= calc_now;
      end
    end
  end

`ifdef CHKV_ERR_CNT_EN
  always_ff @(posedge aclk) begin
    if (!areset) begin
      pkt_good_cnt <= '0;
      pkt_bad_cnt  <= '0;
    end else if (verdict) begin
      if (rcv_match) begin
        if (pkt_good_cnt != 32'hFFFF_FFFF) pkt_good_cnt <= pkt_good_cnt + 32'd1;
      end else begin
        if (pkt_bad_cnt != 32'hFFFF_FFFF) pkt_bad_cnt <= pkt_bad_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_checksum_strip_verify.sv
// Bench for checksum_strip_verify: randomized and directed packets checked against a queue-based packet model.
module tb_checksum_strip_verify;

  localparam int DB = 512;
  localparam int KB = 64;
  localparam int PB = 6;

  typedef struct packed {
    logic [DB-1:0] dat;
    logic [KB-1:0] keep;
    logic [PB-1:0] tid;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic          ok;
    logic [PB-1:0] tid;
    logic [31:0]   rcv;
    logic [31:0]   calc;
  } verd_t;

  logic          aclk = 1'b0;
  logic          areset = 1'b0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DB-1:0] s_tdata = '0;
  logic [KB-1:0] s_tkeep = '0;
  logic [PB-1:0] s_tid = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic [DB-1:0] m_tdata;
  logic [KB-1:0] m_tkeep;
  logic [PB-1:0] m_tid;
  logic          m_tlast;
  logic          chk_done;
  logic          chk_ok;
  logic [PB-1:0] chk_tid;
  logic [31:0]   chk_rcv;
  logic [31:0]   chk_calc;
`ifdef CHKV_ERR_CNT_EN
  logic [31:0]   pkt_good_cnt;
  logic [31:0]   pkt_bad_cnt;
`endif

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    rdy_mode = 2;
  bit    gaps = 1'b0;
  int    exp_good = 0;
  int    exp_bad = 0;
  beat_t tx_q[$];
  beat_t exp_q[$];
  beat_t got_q[$];
  verd_t exp_v[$];
  verd_t got_v[$];
  int    trl_cyc_q[$];
  int    done_cyc_q[$];
  beat_t mon_b;
  verd_t mon_v;

  checksum_strip_verify #(.DATA_BITS(DB), .PID_BITS(PB)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_host_tvalid(s_tvalid), .s_axis_host_tready(s_tready),
    .s_axis_host_tdata(s_tdata), .s_axis_host_tkeep(s_tkeep),
    .s_axis_host_tid(s_tid), .s_axis_host_tlast(s_tlast),
    .m_axis_host_tvalid(m_tvalid), .m_axis_host_tready(m_tready),
    .m_axis_host_tdata(m_tdata), .m_axis_host_tkeep(m_tkeep),
    .m_axis_host_tid(m_tid), .m_axis_host_tlast(m_tlast),
    .chk_done(chk_done), .chk_ok(chk_ok), .chk_tid(chk_tid),
    .chk_rcv(chk_rcv),
`ifdef CHKV_ERR_CNT_EN
    .pkt_good_cnt(pkt_good_cnt), .pkt_bad_cnt(pkt_bad_cnt),
`endif
    .chk_calc(chk_calc)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  initial forever begin
    @(posedge aclk); #1;
    case (rdy_mode)
      0: m_tready = 1'b1;
      1: m_tready = ~m_tready;
      default: m_tready = 1'($urandom_range(0, 1));
    endcase
  end

  // Inputs change just after the rising edge, so the falling edge sees what the next rising edge will sample.
  always @(negedge aclk) begin
    if (areset) begin
      if (m_tvalid && m_tready) begin
        mon_b.dat = m_tdata; mon_b.keep = m_tkeep; mon_b.tid = m_tid; mon_b.last = m_tlast;
        got_q.push_back(mon_b);
      end
      if (chk_done) begin
        mon_v.ok = chk_ok; mon_v.tid = chk_tid; mon_v.rcv = chk_rcv; mon_v.calc = chk_calc;
        got_v.push_back(mon_v);
        done_cyc_q.push_back(cyc);
      end
    end
  end

  function automatic logic [31:0] lane_total(input beat_t b);
    logic [31:0] s = '0;
    for (int i = 0; i < KB; i++) begin
      if (b.keep[i]) s += 32'(b.dat[8*i +: 8]) << (8 * (i % 4));
    end
    return s;
  endfunction

  task automatic model_tx();
    int          n = 0;
    logic [31:0] sum = '0;
    logic [PB-1:0] t0 = '0;
    verd_t       v;
    beat_t       e;
    foreach (tx_q[i]) begin
      if (!tx_q[i].last) begin
        if (n == 0) t0 = tx_q[i].tid;
        sum += lane_total(tx_q[i]);
        exp_q.push_back(tx_q[i]);
        n++;
      end else begin
        if (n > 0) begin
          e = exp_q.pop_back();
          e.last = 1'b1;
          exp_q.push_back(e);
        end
        v.rcv  = tx_q[i].dat[31:0];
        v.calc = sum;
        v.ok   = (v.rcv == sum);
        v.tid  = (n > 0) ? t0 : '0;
        exp_v.push_back(v);
        if (v.ok) exp_good++; else exp_bad++;
        n = 0; sum = '0; t0 = '0;
      end
    end
  endtask

  task automatic add_beat(input logic [DB-1:0] d, input logic [KB-1:0] k,
                          input logic [PB-1:0] t, input logic l);
    beat_t b;
    b.dat = d; b.keep = k; b.tid = t; b.last = l;
    tx_q.push_back(b);
  endtask

  task automatic add_rand_pkt(input int n, input bit good);
    logic [DB-1:0] d;
    logic [KB-1:0] k;
    logic [31:0]   s = '0;
    for (int j = 0; j < n; j++) begin
      for (int l = 0; l < 16; l++) d[32*l +: 32] = $urandom;
      k = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
      add_beat(d, k, 6'($urandom), 1'b0);
      s += lane_total(tx_q[tx_q.size()-1]);
    end
    d = '0;
    d[31:0]  = good ? s : $urandom;
    d[63:32] = $urandom;
    add_beat(d, {$urandom, $urandom}, 6'($urandom), 1'b1);
  endtask

  task automatic clear_q();
    tx_q.delete(); exp_q.delete(); got_q.delete(); exp_v.delete(); got_v.delete();
    trl_cyc_q.delete(); done_cyc_q.delete();
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send(input int stop_after, output int stalls);
    int n_acc = 0;
    int wait_cyc = 0;
    stalls = 0;
    while (tx_q.size() > 0 && wait_cyc < 500) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge aclk); #1;
      end else begin
        s_tvalid = 1'b1; s_tdata = tx_q[0].dat; s_tkeep = tx_q[0].keep;
        s_tid = tx_q[0].tid; s_tlast = tx_q[0].last;
        @(negedge aclk);
        if (s_tready) begin
          if (tx_q[0].last) trl_cyc_q.push_back(cyc);
          void'(tx_q.pop_front());
          n_acc++;
          wait_cyc = 0;
        end else begin
          stalls++;
          wait_cyc++;
        end
        @(posedge aclk); #1;
        if (stop_after > 0 && n_acc == stop_after) break;
      end
    end
    s_tvalid = 1'b0;
    checks++;
    if (wait_cyc >= 500) begin
      errors++;
      $display("FAIL send_timeout: input stalled %0d cycles, required < 500", wait_cyc);
    end
  endtask

  task automatic test_reset();
    areset = 1'b0; s_tvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({m_tvalid, m_tlast, chk_done, chk_ok} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got vld/last/done/ok=%b required 0000", {m_tvalid, m_tlast, chk_done, chk_ok});
    end
    checks++;
    if (m_tdata !== '0 || m_tkeep !== '0 || m_tid !== '0) begin
      errors++;
      $display("FAIL reset_mdata: got dat=%h keep=%h tid=%h required zero", m_tdata[63:0], m_tkeep, m_tid);
    end
    checks++;
    if ({chk_tid, chk_rcv, chk_calc} !== '0) begin
      errors++;
      $display("FAIL reset_status: got tid=%h rcv=%h calc=%h required zero", chk_tid, chk_rcv, chk_calc);
    end
`ifdef CHKV_ERR_CNT_EN
    checks++;
    if (pkt_good_cnt !== 32'd0 || pkt_bad_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: got good=%0d bad=%0d required 0 0", pkt_good_cnt, pkt_bad_cnt);
    end
`endif
    areset = 1'b1; exp_good = 0; exp_bad = 0;
  endtask

  task automatic test_directed();
    logic [31:0]   rcv_t  [4] = '{32'h30, 32'h31, 32'h1, 32'h01010101};
    logic [31:0]   calc_t [4] = '{32'h30, 32'h30, 32'h1, 32'h01010101};
    logic          ok_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [DB-1:0] d;
    logic [PB-1:0] t;
    verd_t         ev;
    int            st;
    rdy_mode = 2; gaps = 1'b1;
    for (int c = 0; c < 4; c++) begin
      clear_q();
      t = 6'(c + 9);
      case (c)
        0, 1: begin
          d = {16{32'h1}};
          repeat (3) add_beat(d, '1, t, 1'b0);
        end
        2: begin
          d = '0; d[31:0] = 32'hFFFF_FFFF; d[63:32] = 32'h2;
          add_beat(d, '1, t, 1'b0);
        end
        default: begin
          d = {16{32'h0101_0101}};
          add_beat(d, 64'hF, t, 1'b0);
        end
      endcase
      d = '0; d[31:0] = rcv_t[c];
      add_beat(d, '1, t, 1'b1);
      model_tx();
      send(0, st);
      drain(40);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL dir%0d_beats: got %0d beats required %0d", c, got_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL dir%0d_beat%0d: got keep=%h tid=%h last=%b dat=%h required keep=%h tid=%h last=%b dat=%h",
                     c, i, got_q[i].keep, got_q[i].tid, got_q[i].last, got_q[i].dat[63:0],
                     exp_q[i].keep, exp_q[i].tid, exp_q[i].last, exp_q[i].dat[63:0]);
          end
        end
      end
      ev.ok = ok_t[c]; ev.tid = t; ev.rcv = rcv_t[c]; ev.calc = calc_t[c];
      checks++;
      if (got_v.size() != 1) begin
        errors++;
        $display("FAIL dir%0d_done_count: got %0d verdicts required 1", c, got_v.size());
      end else begin
        checks++;
        if (got_v[0] !== ev) begin
          errors++;
          $display("FAIL dir%0d_verdict: got ok=%b tid=%h rcv=%h calc=%h required ok=%b tid=%h rcv=%h calc=%h",
                   c, got_v[0].ok, got_v[0].tid, got_v[0].rcv, got_v[0].calc, ev.ok, ev.tid, ev.rcv, ev.calc);
        end
      end
      checks++;
      if (done_cyc_q.size() != 1 || trl_cyc_q.size() != 1 || done_cyc_q[0] != trl_cyc_q[0] + 1) begin
        errors++;
        $display("FAIL dir%0d_done_timing: got %0d dones, required one pulse 1 cycle after trailer", c, done_cyc_q.size());
      end
    end
`ifdef CHKV_ERR_CNT_EN
    checks++;
    if (pkt_good_cnt !== 32'(exp_good) || pkt_bad_cnt !== 32'(exp_bad)) begin
      errors++;
      $display("FAIL dir_cnt: got good=%0d bad=%0d required %0d %0d", pkt_good_cnt, pkt_bad_cnt, exp_good, exp_bad);
    end
`endif
  endtask

  task automatic test_zero_data();
    logic [DB-1:0] d;
    int            st;
    rdy_mode = 1; gaps = 1'b0;
    for (int c = 0; c < 2; c++) begin
      clear_q();
      d = '0; d[31:0] = (c == 0) ? 32'd0 : 32'd5;
      add_beat(d, '1, 6'd3, 1'b1);
      model_tx();
      send(0, st);
      drain(10);
      checks++;
      if (got_q.size() != 0) begin
        errors++;
        $display("FAIL zero%0d_beats: got %0d output beats required 0", c, got_q.size());
      end
      checks++;
      if (got_v.size() != 1) begin
        errors++;
        $display("FAIL zero%0d_done_count: got %0d verdicts required 1", c, got_v.size());
      end else begin
        checks++;
        if (got_v[0].ok !== (c == 0) || got_v[0].calc !== 32'd0 || got_v[0].rcv !== d[31:0]) begin
          errors++;
          $display("FAIL zero%0d_verdict: got ok=%b rcv=%h calc=%h required ok=%b rcv=%h calc=0",
                   c, got_v[0].ok, got_v[0].rcv, got_v[0].calc, c == 0, d[31:0]);
        end
      end
    end
    checks++;
    if (chk_ok !== 1'b0 || chk_rcv !== 32'd5) begin
      errors++;
      $display("FAIL zero_hold: got ok=%b rcv=%h after idle, required 0 and 5", chk_ok, chk_rcv);
    end
  endtask

  task automatic test_random();
    int st;
    clear_q();
    gaps = 1'b1;
    for (int p = 0; p < 25; p++) begin
      rdy_mode = $urandom_range(0, 2);
      add_rand_pkt($urandom_range(0, 5), 1'($urandom_range(0, 1)));
      model_tx();
      send(0, st);
    end
    rdy_mode = 0;
    drain(20);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_beats: got %0d beats required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand_beat%0d: got tid=%h last=%b dat=%h required tid=%h last=%b dat=%h",
                   i, got_q[i].tid, got_q[i].last, got_q[i].dat[63:0], exp_q[i].tid, exp_q[i].last, exp_q[i].dat[63:0]);
        end
      end
    end
    checks++;
    if (got_v.size() != exp_v.size() || done_cyc_q.size() != trl_cyc_q.size()) begin
      errors++;
      $display("FAIL rand_done_count: got %0d verdicts required %0d", got_v.size(), exp_v.size());
    end else begin
      foreach (exp_v[i]) begin
        checks++;
        if (got_v[i] !== exp_v[i] || done_cyc_q[i] != trl_cyc_q[i] + 1) begin
          errors++;
          $display("FAIL rand_verdict%0d: got ok=%b tid=%h rcv=%h calc=%h at +%0d required ok=%b tid=%h rcv=%h calc=%h at +1",
                   i, got_v[i].ok, got_v[i].tid, got_v[i].rcv, got_v[i].calc, done_cyc_q[i] - trl_cyc_q[i],
                   exp_v[i].ok, exp_v[i].tid, exp_v[i].rcv, exp_v[i].calc);
        end
      end
    end
  endtask

  task automatic test_throughput();
    int st;
    clear_q();
    rdy_mode = 0; m_tready = 1'b1; gaps = 1'b0;
    drain(2);
    for (int p = 0; p < 3; p++) add_rand_pkt($urandom_range(3, 5), 1'b1);
    model_tx();
    send(0, st);
    drain(10);
    checks++;
    if (st != 0) begin
      errors++;
      $display("FAIL tput_stalls: got %0d input stall cycles required 0", st);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL tput_beats: got %0d beats required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL tput_beat%0d: got last=%b dat=%h required last=%b dat=%h",
                   i, got_q[i].last, got_q[i].dat[63:0], exp_q[i].last, exp_q[i].dat[63:0]);
        end
      end
    end
    checks++;
    if (got_v.size() != exp_v.size()) begin
      errors++;
      $display("FAIL tput_done_count: got %0d verdicts required %0d", got_v.size(), exp_v.size());
    end else begin
      foreach (exp_v[i]) begin
        checks++;
        if (got_v[i] !== exp_v[i]) begin
          errors++;
          $display("FAIL tput_verdict%0d: got ok=%b calc=%h required ok=%b calc=%h",
                   i, got_v[i].ok, got_v[i].calc, exp_v[i].ok, exp_v[i].calc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int st;
    clear_q();
    rdy_mode = 1; gaps = 1'b0;
    add_rand_pkt(4, 1'b1);
    model_tx();
    send(0, st);
    add_rand_pkt(4, 1'b1);
    send(1, st);
    tx_q.delete();
    areset = 1'b0;
    @(posedge aclk); #1;
    checks++;
    if ({m_tvalid, chk_done, chk_ok} !== 3'b0 || chk_calc !== 32'd0) begin
      errors++;
      $display("FAIL b2b_reset_out: got vld/done/ok=%b calc=%h required 000 and 0", {m_tvalid, chk_done, chk_ok}, chk_calc);
    end
    @(posedge aclk); #1;
    areset = 1'b1; exp_good = 0; exp_bad = 0;
    drain(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_beats: got %0d beats required %0d (first packet only)", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_beat%0d: got last=%b dat=%h required last=%b dat=%h",
                   i, got_q[i].last, got_q[i].dat[63:0], exp_q[i].last, exp_q[i].dat[63:0]);
        end
      end
    end
    checks++;
    if (got_v.size() != 1 || got_v[0] !== exp_v[0]) begin
      errors++;
      $display("FAIL b2b_verdicts: got %0d verdicts required exactly the first packet's", got_v.size());
    end
    clear_q();
    add_rand_pkt(4, 1'b1);
    model_tx();
    send(0, st);
    drain(10);
    checks++;
    if (got_v.size() != 1 || got_v[0] !== exp_v[0] || got_v[0].ok !== 1'b1 || got_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_after_reset: got %0d verdicts %0d beats required 1 ok verdict and 4 beats", got_v.size(), got_q.size());
    end
`ifdef CHKV_ERR_CNT_EN
    checks++;
    if (pkt_good_cnt !== 32'd1 || pkt_bad_cnt !== 32'd0) begin
      errors++;
      $display("FAIL b2b_cnt: got good=%0d bad=%0d required 1 0", pkt_good_cnt, pkt_bad_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_data();
    test_random();
    test_throughput();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
